// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder and its line front end.
package sccb_pkg;

    localparam int BYTE_W     = 8;
    localparam int SYNC_DEPTH = 2;

    // Direction bit carried in the LSB of the device ID byte.
    localparam logic SCCB_WRITE = 1'b0;
    localparam logic SCCB_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RD_LOAD   = 4'd7,
        ST_RDATA     = 4'd8,
        ST_RD_ACK    = 4'd9,
        ST_IGNORE    = 4'd10
    } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises sioc/siod into the clk domain and reports sioc edges plus
// START/STOP conditions as registered one-cycle pulses.
module sccb_line_sync
    import sccb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sioc,
    input  logic siod,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic [SYNC_DEPTH-1:0] scl_sync_r;
    logic [SYNC_DEPTH-1:0] sda_sync_r;
    logic                  scl_d_r;
    logic                  sda_d_r;
    logic                  scl_now_s;
    logic                  sda_now_s;
    logic                  scl_rise_r;
    logic                  scl_fall_r;
    logic                  sda_r;
    logic                  start_r;
    logic                  stop_r;

    assign scl_now_s = scl_sync_r[SYNC_DEPTH-1];
    assign sda_now_s = sda_sync_r[SYNC_DEPTH-1];

    // Synchroniser chains, edge register and registered event pulses (idle bus reads high).
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {SYNC_DEPTH{1'b1}};
            sda_sync_r <= {SYNC_DEPTH{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            sda_r      <= 1'b1;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_DEPTH-2:0], sioc};
            sda_sync_r <= {sda_sync_r[SYNC_DEPTH-2:0], siod};
            scl_d_r    <= scl_now_s;
            sda_d_r    <= sda_now_s;
            scl_rise_r <= scl_now_s & ~scl_d_r;
            scl_fall_r <= ~scl_now_s & scl_d_r;
            sda_r      <= sda_now_s;
            // sioc must be high before and after the siod transition
            start_r    <= scl_d_r & scl_now_s & sda_d_r & ~sda_now_s;
            stop_r     <= scl_d_r & scl_now_s & ~sda_d_r & sda_now_s;
        end
    end

    assign scl_rise = scl_rise_r;
    assign scl_fall = scl_fall_r;
    assign sda_s    = sda_r;
    assign start    = start_r;
    assign stop     = stop_r;

endmodule

// File: rtl/sccb_responder.sv
// SCCB/I2C target: matches the device ID, presents writes on a parallel
// register port and serves reads from rd_data at the auto-incrementing pointer.
// A received bit is only counted once sioc falls again, so the sioc rise that
// precedes a STOP is not mistaken for the start of a new byte.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = 8'h42,
    parameter bit         DRIVE_ACK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc,
    inout  wire        siod,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       err
);

    logic scl_rise, scl_fall, sda_s, start, stop;

    sccb_line_sync u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .sioc     (sioc),
        .siod     (siod),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop)
    );

    sccb_state_e        state_r, state_nxt;
    logic [2:0]         bit_cnt_r, bit_cnt_nxt;
    logic [BYTE_W-1:0]  shift_r, shift_nxt;
    logic               pend_r, pend_nxt;      // sioc rise seen, waiting for its fall
    logic               ack_r, ack_nxt;        // initiator ACK/NACK bit after a read byte
    logic               oe_r, oe_nxt;          // 1 = pull siod low
    logic               wr_en_r, wr_en_nxt;
    logic [7:0]         wr_addr_r, wr_addr_nxt;
    logic [7:0]         wr_data_r, wr_data_nxt;
    logic [7:0]         rd_addr_r, rd_addr_nxt;
    logic               busy_r, busy_nxt;
    logic               err_r, err_nxt;
    logic [BYTE_W-1:0]  byte_in_s;
    logic               id_match_s;
    logic               in_byte_s;

    // State and datapath registers; reset releases siod on the first edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            pend_r    <= 1'b0;
            ack_r     <= 1'b1;
            oe_r      <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'h00;
            wr_data_r <= 8'h00;
            rd_addr_r <= 8'h00;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            shift_r   <= shift_nxt;
            pend_r    <= pend_nxt;
            ack_r     <= ack_nxt;
            oe_r      <= oe_nxt;
            wr_en_r   <= wr_en_nxt;
            wr_addr_r <= wr_addr_nxt;
            wr_data_r <= wr_data_nxt;
            rd_addr_r <= rd_addr_nxt;
            busy_r    <= busy_nxt;
            err_r     <= err_nxt;
        end
    end

    // Next-state and output logic; START/STOP take priority over sioc edges.
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shift_nxt   = shift_r;
        pend_nxt    = pend_r;
        ack_nxt     = ack_r;
        oe_nxt      = oe_r;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_r;
        wr_data_nxt = wr_data_r;
        rd_addr_nxt = rd_addr_r;
        busy_nxt    = busy_r;
        err_nxt     = 1'b0;
        byte_in_s   = {shift_r[6:0], sda_s};
        id_match_s  = (shift_r == DEVICE_ID) || (shift_r == (DEVICE_ID | 8'h01));
        in_byte_s   = (state_r == ST_ID) || (state_r == ST_SUB) ||
                      (state_r == ST_WDATA) || (state_r == ST_RDATA);

        if (stop) begin
            state_nxt   = ST_IDLE;
            oe_nxt      = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
            pend_nxt    = 1'b0;
            err_nxt     = in_byte_s && (bit_cnt_r != 3'd0);
        end else if (start) begin
            state_nxt   = ST_ID;
            oe_nxt      = 1'b0;
            bit_cnt_nxt = 3'd0;
            pend_nxt    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    oe_nxt = 1'b0;
                end
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_nxt = byte_in_s;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_nxt = 3'd0;
                            pend_nxt    = 1'b0;
                            case (state_r)
                                ST_ID:   state_nxt = ST_ID_ACK;
                                ST_SUB:  state_nxt = ST_SUB_ACK;
                                default: begin
                                    state_nxt   = ST_WDATA_ACK;
                                    wr_en_nxt   = 1'b1;
                                    wr_addr_nxt = rd_addr_r;
                                    wr_data_nxt = byte_in_s;
                                    rd_addr_nxt = rd_addr_r + 8'd1;
                                end
                            endcase
                        end else begin
                            pend_nxt = 1'b1;
                        end
                    end else if (scl_fall && pend_r) begin
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        pend_nxt    = 1'b0;
                    end else begin
                        pend_nxt = pend_r;
                    end
                end
                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK, ST_RD_ACK: begin
                    if ((state_r == ST_ID_ACK) && !id_match_s) begin
                        state_nxt = ST_IGNORE;
                        busy_nxt  = 1'b0;
                        oe_nxt    = 1'b0;
                    end else begin
                        if (state_r == ST_ID_ACK) begin
                            busy_nxt = 1'b1;
                        end else begin
                            busy_nxt = busy_r;
                        end
                        if (state_r == ST_SUB_ACK) begin
                            rd_addr_nxt = shift_r;
                        end else begin
                            rd_addr_nxt = rd_addr_r;
                        end
                        // first fall opens the ACK slot, the fall after the 9th rise closes it
                        if (scl_rise) begin
                            pend_nxt = 1'b1;
                            ack_nxt  = sda_s;
                        end else if (scl_fall && !pend_r) begin
                            oe_nxt = (state_r == ST_RD_ACK) ? 1'b0 : DRIVE_ACK;
                        end else if (scl_fall) begin
                            oe_nxt   = 1'b0;
                            pend_nxt = 1'b0;
                            case (state_r)
                                ST_ID_ACK:    state_nxt = (shift_r[0] == SCCB_READ) ? ST_RD_LOAD : ST_SUB;
                                ST_SUB_ACK:   state_nxt = ST_WDATA;
                                ST_WDATA_ACK: state_nxt = ST_WDATA;
                                default: begin
                                    if (ack_r == 1'b0) begin
                                        rd_addr_nxt = rd_addr_r + 8'd1;
                                        state_nxt   = ST_RD_LOAD;
                                    end else begin
                                        state_nxt = ST_IGNORE;
                                        busy_nxt  = 1'b0;
                                    end
                                end
                            endcase
                        end else begin
                            pend_nxt = pend_r;
                        end
                    end
                end
                ST_RD_LOAD: begin
                    shift_nxt   = rd_data;
                    oe_nxt      = ~rd_data[7];
                    bit_cnt_nxt = 3'd0;
                    pend_nxt    = 1'b0;
                    state_nxt   = ST_RDATA;
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_r == 3'd7) begin
                            state_nxt   = ST_RD_ACK;
                            bit_cnt_nxt = 3'd0;
                            pend_nxt    = 1'b0;
                        end else begin
                            pend_nxt = 1'b1;
                        end
                    end else if (scl_fall && pend_r) begin
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                        pend_nxt    = 1'b0;
                        shift_nxt   = {shift_r[6:0], 1'b0};
                        oe_nxt      = ~shift_r[6];
                    end else begin
                        pend_nxt = pend_r;
                    end
                end
                ST_IGNORE: begin
                    oe_nxt   = 1'b0;
                    busy_nxt = 1'b0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    oe_nxt    = 1'b0;
                end
            endcase
        end
    end

    assign siod    = oe_r ? 1'b0 : 1'bz;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign rd_addr = rd_addr_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a bit-banged SCCB initiator drives the bus
// and every expectation below is a hand-computed constant.
module tb_sccb_responder;

    localparam int Q = 10;  // clk cycles per quarter bit

    logic       clk = 1'b0;
    logic       rst;
    logic       sioc;
    logic       m_oe;
    wire        siod;
    logic       wr_en, busy, err;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int drv_cnt = 0;
    logic [7:0] wa_log [0:15];
    logic [7:0] wd_log [0:15];

    always #5 clk = ~clk;

    assign siod = m_oe ? 1'b0 : 1'bz;
    pullup (siod);

    // register file stand-in: only address 0x0A holds a non-zero value
    assign rd_data = (rd_addr == 8'h0A) ? 8'h76 : 8'h00;

    sccb_responder #(.DEVICE_ID(8'h42), .DRIVE_ACK(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .sioc    (sioc),
        .siod    (siod),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .err     (err)
    );

    // Bus observers: log write strobes, count err/busy cycles and target pull-downs.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_log[wr_cnt[3:0]] <= wr_addr;
            wd_log[wr_cnt[3:0]] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if ((siod === 1'b0) && (m_oe == 1'b0)) drv_cnt <= drv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; sioc = 1'b1; wait_clk(2*Q);
        m_oe = 1'b1; wait_clk(2*Q);
        sioc = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_rstart();
        m_oe = 1'b0; wait_clk(Q);
        sioc = 1'b1; wait_clk(Q);
        m_oe = 1'b1; wait_clk(Q);
        sioc = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; wait_clk(Q);
        sioc = 1'b1; wait_clk(2*Q);
        m_oe = 1'b0; wait_clk(2*Q);
    endtask

    task automatic bus_bit(input logic b);
        m_oe = ~b; wait_clk(Q);
        sioc = 1'b1; wait_clk(2*Q);
        sioc = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        m_oe = 1'b0; wait_clk(Q);
        sioc = 1'b1; wait_clk(Q);
        ack = siod;  wait_clk(Q);
        sioc = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_read(output logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) begin
            m_oe = 1'b0; wait_clk(Q);
            sioc = 1'b1; wait_clk(Q);
            b[i] = siod; wait_clk(Q);
            sioc = 1'b0; wait_clk(Q);
        end
        m_oe = ~nack; wait_clk(Q);
        sioc = 1'b1;  wait_clk(2*Q);
        sioc = 1'b0;  wait_clk(Q);
    endtask

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] rb;
        int         w0, e0, b0, d0;

        rst = 1'b1; sioc = 1'b1; m_oe = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_rd_addr", rd_addr, 8'h00);
        chk("rst_siod", siod, 1'b1);

        // 3-phase write 0x42, 0x12, 0x80
        w0 = wr_cnt;
        bus_start();
        bus_byte(8'h42, a0);
        chk("w1_busy", busy, 1'b1);
        bus_byte(8'h12, a1);
        bus_byte(8'h80, a2);
        bus_stop();
        chk("w1_ack_id", a0, 1'b0);
        chk("w1_ack_sub", a1, 1'b0);
        chk("w1_ack_data", a2, 1'b0);
        chk("w1_wr_count", wr_cnt - w0, 1);
        chk("w1_wr_addr", wa_log[w0[3:0]], 8'h12);
        chk("w1_wr_data", wd_log[w0[3:0]], 8'h80);
        chk("w1_rd_addr", rd_addr, 8'h13);
        chk("w1_busy_end", busy, 1'b0);
        chk("w1_err", err_cnt, 0);

        // foreign ID 0x60: bus untouched
        w0 = wr_cnt; b0 = busy_cnt; d0 = drv_cnt;
        bus_start();
        bus_byte(8'h60, a0);
        bus_byte(8'h12, a1);
        bus_byte(8'h80, a2);
        bus_stop();
        chk("id_miss_ack", {a0, a1, a2}, 3'b111);
        chk("id_miss_wr", wr_cnt - w0, 0);
        chk("id_miss_busy", busy_cnt - b0, 0);
        chk("id_miss_drive", drv_cnt - d0, 0);
        chk("id_miss_rd_addr", rd_addr, 8'h13);

        // 2-phase write sets the pointer, then 2-phase read with NACK
        w0 = wr_cnt;
        bus_start();
        bus_byte(8'h42, a0);
        bus_byte(8'h0A, a1);
        bus_stop();
        chk("ptr_wr", wr_cnt - w0, 0);
        chk("ptr_rd_addr", rd_addr, 8'h0A);
        bus_start();
        bus_byte(8'h43, a0);
        chk("rd_ack_id", a0, 1'b0);
        bus_read(rb, 1'b1);
        bus_stop();
        chk("rd_byte", rb, 8'h76);
        chk("rd_rd_addr", rd_addr, 8'h0A);
        chk("rd_busy_end", busy, 1'b0);
        chk("rd_err", err_cnt, 0);

        // burst write across the pointer wrap
        w0 = wr_cnt;
        bus_start();
        bus_byte(8'h42, a0);
        bus_byte(8'hFF, a1);
        bus_byte(8'h11, a2);
        bus_byte(8'h22, a3);
        bus_stop();
        chk("burst_count", wr_cnt - w0, 2);
        chk("burst_a0", wa_log[w0[3:0]], 8'hFF);
        chk("burst_d0", wd_log[w0[3:0]], 8'h11);
        chk("burst_a1", wa_log[w0[3:0] + 4'd1], 8'h00);
        chk("burst_d1", wd_log[w0[3:0] + 4'd1], 8'h22);
        chk("burst_rd_addr", rd_addr, 8'h01);

        // STOP after 4 data bits
        w0 = wr_cnt; e0 = err_cnt;
        bus_start();
        bus_byte(8'h42, a0);
        bus_byte(8'h05, a1);
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
        bus_stop();
        chk("part_err", err_cnt - e0, 1);
        chk("part_wr", wr_cnt - w0, 0);
        chk("part_busy", busy, 1'b0);
        chk("part_rd_addr", rd_addr, 8'h05);

        // STOP mid-SUB keeps the pointer
        e0 = err_cnt;
        bus_start();
        bus_byte(8'h42, a0);
        bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b1);
        bus_stop();
        chk("sub_stop_err", err_cnt - e0, 1);
        chk("sub_stop_rd_addr", rd_addr, 8'h05);

        // repeated START mid-SUB restarts the ID phase
        w0 = wr_cnt; e0 = err_cnt;
        bus_start();
        bus_byte(8'h42, a0);
        bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
        bus_rstart();
        bus_byte(8'h42, a0);
        bus_byte(8'h20, a1);
        bus_byte(8'h5A, a2);
        bus_stop();
        chk("rs_err", err_cnt - e0, 0);
        chk("rs_ack", {a0, a1, a2}, 3'b000);
        chk("rs_wr_count", wr_cnt - w0, 1);
        chk("rs_wr_addr", wa_log[w0[3:0]], 8'h20);
        chk("rs_wr_data", wd_log[w0[3:0]], 8'h5A);
        chk("rs_rd_addr", rd_addr, 8'h21);

        // reset while the target pulls siod low during a read byte
        bus_start();
        bus_byte(8'h43, a0);
        chk("rr_ack", a0, 1'b0);
        chk("rr_drive_low", siod, 1'b0);
        rst = 1'b1;
        wait_clk(1);
        chk("rr_siod", siod, 1'b1);
        chk("rr_busy", busy, 1'b0);
        chk("rr_wr_en", wr_en, 1'b0);
        chk("rr_err", err, 1'b0);
        chk("rr_wr_addr", wr_addr, 8'h00);
        chk("rr_wr_data", wr_data, 8'h00);
        chk("rr_rd_addr", rd_addr, 8'h00);
        wait_clk(2);
        rst = 1'b0;
        sioc = 1'b1; m_oe = 1'b0;
        wait_clk(4*Q);
        chk("rr_idle_siod", siod, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
